// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

    localparam int PHC_REG_AW         = 3;
    localparam int PHC_BRANCH_PENALTY = 2;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BR_FLUSH = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    // Opcode the ID decoder matches to raise exe_mem_read further down the pipe.
    localparam logic [3:0] OP_LOAD = 4'b1000;

    typedef struct packed {
        logic pc_write;
        logic pc_sel_branch;
        logic if_id_write;
        logic if_id_flush;
        logic id_exe_flush;
        logic pipe_hold;
    } ctrl_t;

    function automatic ctrl_t ctrl_run_default();
        ctrl_t c;
        c.pc_write      = 1'b1;
        c.pc_sel_branch = 1'b0;
        c.if_id_write   = 1'b1;
        c.if_id_flush   = 1'b0;
        c.id_exe_flush  = 1'b0;
        c.pipe_hold     = 1'b0;
        return c;
    endfunction

    function automatic ctrl_t ctrl_in_reset();
        ctrl_t c;
        c.pc_write      = 1'b0;
        c.pc_sel_branch = 1'b0;
        c.if_id_write   = 1'b0;
        c.if_id_flush   = 1'b1;
        c.id_exe_flush  = 1'b1;
        c.pipe_hold     = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// rtl/pipe_hazard_ctrl_hazard_cmp.sv - combinational load-use register comparator
module hazard_cmp #(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_mem_read,
    input  logic              exe_regwrite,
    output logic              hazard
);

    // Register 0 is an ordinary register in this core, so no zero-reg exclusion.
    assign hazard = exe_mem_read && exe_regwrite &&
                    ((exe_dest == id_rs) || (id_uses_rt && (exe_dest == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / branch-flush / mem-wait sequencer; HAZARD_PERF_CNT_EN adds stall/flush counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW         = PHC_REG_AW,
    parameter int BRANCH_PENALTY = PHC_BRANCH_PENALTY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_mem_read,
    input  logic              exe_regwrite,
    input  logic              exe_branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              pc_sel_branch,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_exe_flush,
    output logic              pipe_hold,
    output logic [1:0]        busy_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam logic [2:0] PEN_M1    = 3'(BRANCH_PENALTY - 1);
    localparam bit         MULTI_PEN = (BRANCH_PENALTY > 1);

    logic [1:0] state, state_nxt;
    logic [1:0] saved_state, saved_nxt;
    logic [1:0] eff_state;
    logic [2:0] counter, counter_nxt;
    logic       load_use;
    logic       stall_evt;
    ctrl_t      ctrl;

    hazard_cmp #(.REG_AW(REG_AW)) u_hazard_cmp (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .exe_dest     (exe_dest),
        .exe_mem_read (exe_mem_read),
        .exe_regwrite (exe_regwrite),
        .hazard       (load_use)
    );

    // MEM_WAIT behaves as whichever state it interrupted once mem_busy drops.
    always_comb begin
        unique case (state)
            ST_MEM_WAIT: eff_state = saved_state;
            ST_BR_FLUSH: eff_state = ST_BR_FLUSH;
            default:     eff_state = ST_RUN;
        endcase
    end

    always_comb begin
        ctrl        = ctrl_run_default();
        state_nxt   = eff_state;
        saved_nxt   = saved_state;
        counter_nxt = counter;
        stall_evt   = 1'b0;
        if (mem_busy) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.pipe_hold   = 1'b1;
            state_nxt        = ST_MEM_WAIT;
            saved_nxt        = eff_state;
            stall_evt        = 1'b1;
        end else if (eff_state == ST_BR_FLUSH) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_exe_flush = 1'b1;
            if (counter <= 3'd1) begin
                state_nxt   = ST_RUN;
                counter_nxt = 3'd0;
            end else begin
                counter_nxt = counter - 3'd1;
            end
        end else if (exe_branch_taken) begin
            ctrl.pc_sel_branch = 1'b1;
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_exe_flush  = 1'b1;
            if (MULTI_PEN) begin
                state_nxt   = ST_BR_FLUSH;
                counter_nxt = PEN_M1;
            end
        end else if (load_use) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_exe_flush = 1'b1;
            stall_evt         = 1'b1;
        end
        if (!reset) begin
            ctrl      = ctrl_in_reset();
            stall_evt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            counter     <= 3'd0;
        end else begin
            state       <= state_nxt;
            saved_state <= saved_nxt;
            counter     <= counter_nxt;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_sel_branch = ctrl.pc_sel_branch;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_exe_flush  = ctrl.id_exe_flush;
    assign pipe_hold     = ctrl.pipe_hold;
    assign busy_state    = reset ? state : ST_RUN;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_evt && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (ctrl.if_id_flush && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench against a cycle-count reference model
module tb_pipe_hazard_ctrl;

    localparam int AW = 3;
    localparam int BP = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, exe_dest;
    logic          id_uses_rt, exe_mem_read, exe_regwrite, exe_branch_taken, mem_busy;
    logic          pc_write, pc_sel_branch, if_id_write, if_id_flush, id_exe_flush, pipe_hold;
    logic [1:0]    busy_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0]   stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remaining flush cycles after the branch, and the visible state code.
    int m_left = 0, nx_left = 0;
    int m_view = 0, nx_view = 0;
    int m_stall = 0, nx_stall = 0;
    int m_flush = 0, nx_flush = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.REG_AW(AW), .BRANCH_PENALTY(BP)) dut (
        .clock            (clock),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .exe_dest         (exe_dest),
        .exe_mem_read     (exe_mem_read),
        .exe_regwrite     (exe_regwrite),
        .exe_branch_taken (exe_branch_taken),
        .mem_busy         (mem_busy),
        .pc_write         (pc_write),
        .pc_sel_branch    (pc_sel_branch),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_exe_flush     (id_exe_flush),
        .pipe_hold        (pipe_hold),
        .busy_state       (busy_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic mr, input logic rw, input int dst,
                         input int rs, input int rt, input logic urt, input logic br, input logic mb);
        reset = rst; exe_mem_read = mr; exe_regwrite = rw; exe_dest = AW'(dst);
        id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rt = urt; exe_branch_taken = br; mem_busy = mb;
    endtask

    task automatic drive_idle();
        drive(1'b1, 1'b0, 1'b0, 0, 1, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive_random();
        reset            = ($urandom_range(0, 49) != 0);
        exe_mem_read     = $urandom_range(0, 1);
        exe_regwrite     = $urandom_range(0, 3) != 0;
        exe_dest         = AW'($urandom_range(0, 3));
        id_rs            = AW'($urandom_range(0, 3));
        id_rt            = AW'($urandom_range(0, 3));
        id_uses_rt       = $urandom_range(0, 1);
        exe_branch_taken = ($urandom_range(0, 4) == 0);
        mem_busy         = ($urandom_range(0, 5) == 0);
    endtask

    // At the falling edge: derive this cycle's outputs from the rules and compare.
    task automatic compare();
        logic lu;
        logic e_pcw, e_sel, e_ifw, e_iff, e_idf, e_hold;
        int   e_bs;
        @(negedge clock);
        lu = exe_mem_read && exe_regwrite &&
             ((exe_dest == id_rs) || (id_uses_rt && (exe_dest == id_rt)));
        e_pcw = 1; e_sel = 0; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0;
        e_bs = m_view;
        nx_left = m_left;
        nx_stall = m_stall;
        nx_flush = m_flush;
        if (!reset) begin
            e_pcw = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_bs = 0;
            nx_left = 0; nx_view = 0; nx_stall = 0; nx_flush = 0;
        end else if (mem_busy) begin
            e_pcw = 0; e_ifw = 0; e_hold = 1;
            nx_view = 2;
            nx_stall = m_stall + 1;
        end else begin
            if (m_left > 0) begin
                e_iff = 1; e_idf = 1;
                nx_left = m_left - 1;
            end else if (exe_branch_taken) begin
                e_sel = 1; e_iff = 1; e_idf = 1;
                nx_left = BP - 1;
            end else if (lu) begin
                e_pcw = 0; e_ifw = 0; e_idf = 1;
                nx_stall = m_stall + 1;
            end
            nx_view = (nx_left > 0) ? 1 : 0;
            if (e_iff) nx_flush = m_flush + 1;
        end
        if (nx_stall > 65535) nx_stall = 65535;
        if (nx_flush > 65535) nx_flush = 65535;
        check("pc_write", 32'(pc_write), 32'(e_pcw));
        check("pc_sel_branch", 32'(pc_sel_branch), 32'(e_sel));
        check("if_id_write", 32'(if_id_write), 32'(e_ifw));
        check("if_id_flush", 32'(if_id_flush), 32'(e_iff));
        check("id_exe_flush", 32'(id_exe_flush), 32'(e_idf));
        check("pipe_hold", 32'(pipe_hold), 32'(e_hold));
        check("busy_state", 32'(busy_state), 32'(e_bs));
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), reset ? 32'(m_stall) : 32'd0);
        check("flush_cnt", 32'(flush_cnt), reset ? 32'(m_flush) : 32'd0);
`endif
    endtask

    task automatic advance();
        @(posedge clock);
        m_left = nx_left; m_view = nx_view; m_stall = nx_stall; m_flush = nx_flush;
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        #1;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            drive_random();
            reset = 1'b0;
            compare();
            check("rst_if_id_flush", 32'(if_id_flush), 32'd1);
            check("rst_pc_write", 32'(pc_write), 32'd0);
            advance();
        end
        drive_idle();
        compare();
        check("rel_pc_write", 32'(pc_write), 32'd1);
        advance();

        // Load-use on rs, then normal flow
        drive(1'b1, 1'b1, 1'b1, 3, 3, 5, 1'b0, 1'b0, 1'b0);
        compare();
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_id_exe_flush", 32'(id_exe_flush), 32'd1);
        advance();
        drive(1'b1, 1'b0, 1'b1, 3, 3, 5, 1'b0, 1'b0, 1'b0);
        compare();
        check("lu_after_pc_write", 32'(pc_write), 32'd1);
        advance();

        // Taken branch: flush at N and N+1, RUN at N+2
        drive(1'b1, 1'b0, 1'b0, 0, 1, 2, 1'b0, 1'b1, 1'b0);
        compare();
        check("br_sel", 32'(pc_sel_branch), 32'd1);
        advance();
        drive_idle();
        compare();
        check("br_n1_flush", 32'(if_id_flush), 32'd1);
        check("br_n1_state", 32'(busy_state), 32'd1);
        advance();
        compare();
        check("br_n2_state", 32'(busy_state), 32'd0);
        check("br_n2_flush", 32'(if_id_flush), 32'd0);
        advance();

        // Branch and load-use together: branch only
        drive(1'b1, 1'b1, 1'b1, 4, 4, 4, 1'b1, 1'b1, 1'b0);
        compare();
        check("brlu_pc_write", 32'(pc_write), 32'd1);
        check("brlu_sel", 32'(pc_sel_branch), 32'd1);
        advance();

        // Now in BR_FLUSH count 1: mem_busy for 4 cycles, then one flush cycle, then RUN
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 1, 2, 1'b0, 1'b1, 1'b1);
            compare();
            check("mw_hold", 32'(pipe_hold), 32'd1);
            advance();
        end
        drive_idle();
        compare();
        check("mw_ret_flush", 32'(if_id_flush), 32'd1);
        advance();
        compare();
        check("mw_run_state", 32'(busy_state), 32'd0);
        advance();

`ifdef HAZARD_PERF_CNT_EN
        // Three load-use cycles plus five busy cycles from a fresh reset
        drive(1'b0, 1'b0, 1'b0, 0, 1, 2, 1'b0, 1'b0, 1'b0);
        compare(); advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 2, 7, 2, 1'b1, 1'b0, 1'b0);
            compare(); advance();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 0, 1, 2, 1'b0, 1'b0, 1'b1);
            compare(); advance();
        end
        drive_idle();
        compare();
        check("perf_stall8", 32'(stall_cnt), 32'd8);
        advance();
        drive(1'b1, 1'b0, 1'b0, 0, 1, 2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) advance_quiet();
        compare();
        check("perf_sat", 32'(stall_cnt), 32'd65535);
        advance();
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive_random();
            compare();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Long busy stretch: model advanced without per-cycle output checks.
    task automatic advance_quiet();
        @(posedge clock);
        m_view = 2;
        m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        #1;
    endtask
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 16-bit 5-stage core; drives the flush and hold controls of the IF/ID and ID/EXE buffers and the PC write enable.
- Detects load-use hazards, sequences taken-branch flushes, and freezes the front end while data memory is busy.
- Sits beside the ID stage; takes its inputs from the ID decode and from the EXE-stage buffer outputs.

Parameters:
- REG_AW, 3, register-address width (matches id_rs/id_rt/exe_rd).
- BRANCH_PENALTY, 2, IF/ID flush cycles per taken branch (legal range 1..7).

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- id_rs  in  REG_AW  source reg 1 of the instruction in ID
- id_rt  in  REG_AW  source reg 2 of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt
- exe_dest  in  REG_AW  destination reg of the instruction in EXE (post reg_dst mux)
- exe_mem_read  in  1  EXE instruction is a load
- exe_regwrite  in  1  EXE instruction writes a register
- exe_branch_taken  in  1  branch resolved taken in EXE (gt/le compare result)
- mem_busy  in  1  data memory not ready; MEM stage must hold
- pc_write  out  1  PC update enable
- pc_sel_branch  out  1  select exe_bra_pc as next PC
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  zero the IF/ID contents
- id_exe_flush  out  1  drives the ID/EXE buffer flush input
- pipe_hold  out  1  hold the ID/EXE and EXE/MEM buffers
- busy_state  out  2  current FSM state (debug)

Behaviour:
- State register only (asynchronous clear on reset=0). All other outputs are combinational from state and inputs, so every response appears in the same cycle as its cause.
- While reset=0: state=RUN, counter=0. All outputs are forced as follows: pc_write=0, if_id_write=0, if_id_flush=1, id_exe_flush=1, pc_sel_branch=0, pipe_hold=0, busy_state=0.
- States: RUN(0), BR_FLUSH(1), MEM_WAIT(2). Encoding 3 is illegal and returns to RUN on the next edge.
- Default outputs in RUN with no event: pc_write=1, if_id_write=1, all flushes=0, pipe_hold=0, pc_sel_branch=0.
- Priority inside RUN: mem_busy > exe_branch_taken > load-use.
- mem_busy=1 (any state):
  - pc_write=0, if_id_write=0, pipe_hold=1; no flush.
  - Next state is MEM_WAIT; the saved state and counter are retained.
  - A branch or load-use presented while busy is ignored; it is re-evaluated once mem_busy falls, because the inputs are held.
- MEM_WAIT:
  - Outputs are as for mem_busy.
  - When mem_busy=0, return to the saved state (RUN or BR_FLUSH with the preserved count), with that state's outputs in the same cycle.
- Taken branch (RUN, mem_busy=0):
  - pc_sel_branch=1, pc_write=1, if_id_flush=1, id_exe_flush=1.
  - If BRANCH_PENALTY>1: counter=BRANCH_PENALTY-1 and next state is BR_FLUSH. Otherwise stay in RUN.
- BR_FLUSH:
  - if_id_flush=1, id_exe_flush=1, pc_write=1, pc_sel_branch=0.
  - Counter decrements each cycle; return to RUN when the counter reaches 1 at the edge.
  - exe_branch_taken is ignored, because the EXE stage holds a bubble.
- Load-use (RUN): exe_mem_read & exe_regwrite & (exe_dest==id_rs | (id_uses_rt & exe_dest==id_rt)).
  - Response: pc_write=0, if_id_write=0, id_exe_flush=1 for exactly this cycle; state stays RUN.
  - Register 0 is not special.
- Branch and load-use in the same cycle: the branch wins; the load-use hazard is discarded because its consumer is flushed.
- reset asserted mid-BR_FLUSH or mid-MEM_WAIT aborts the sequence immediately; the counter clears.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds 16-bit saturating outputs stall_cnt (load-use cycles plus mem_busy cycles) and flush_cnt (cycles with if_id_flush=1 while reset=1). Both clear on reset.
- Undefined: the counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - State encodings RUN/BR_FLUSH/MEM_WAIT.
  - REG_AW.
  - The default BRANCH_PENALTY.
  - The load opcode constant used by the decode that drives exe_mem_read.
- One natural sub-module: hazard_cmp, the combinational load-use comparator, reusable by the forwarding unit.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> flushes=1, pc_write=0, busy_state=0. Release -> pc_write=1 on the first cycle.
- Load-use: exe_mem_read=1, exe_regwrite=1, exe_dest=3, id_rs=3 -> one cycle with pc_write=0, if_id_write=0, id_exe_flush=1. Next cycle, with exe_mem_read=0, normal flow.
- Branch with BRANCH_PENALTY=2: exe_branch_taken=1 in cycle N -> pc_sel_branch=1 at N. if_id_flush=1 at N and N+1. RUN at N+2.
- Branch and load-use in the same cycle -> branch response only; pc_write=1, pc_sel_branch=1.
- mem_busy=1 for 4 cycles entering at BR_FLUSH count 1 -> pipe_hold=1 for 4 cycles. Then one BR_FLUSH cycle, then RUN.
- With HAZARD_PERF_CNT_EN: 3 load-use events plus a 5-cycle mem_busy -> stall_cnt=8. Forced 70000 stalls -> stall_cnt saturates at 65535.
